dmem_access_ctrl: RTL and testbench

//  Initiator side of the data-memory port: accepts load/store requests from the pipeline via

---
 rtl/dmem_access_ctrl.sv | 96 +++++++++
 tb/tb_dmem_access_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: initiator side of the data-memory port with address range checking
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake; req_we 1=store, req_addr word address, req_wdata store data
//   rsp_valid/rsp_ready           response handshake; rsp_rdata load data, rsp_err out-of-range / verify error
//   Addr, WriDat, WE2             memory address, write data, one-cycle write enable
//   ReaDat                        memory read data, combinational from Addr
// Optional macro DMEM_WRITE_VERIFY_EN adds a VERIFY cycle that reads back each store and flags a mismatch.
module dmem_access_ctrl #(
    parameter int AWIDTH  = 32,
    parameter int ALENGTH = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [AWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [AWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [AWIDTH-1:0] Addr,
    output logic [AWIDTH-1:0] WriDat,
    output logic              WE2,
    input  logic [AWIDTH-1:0] ReaDat
);
`ifdef DMEM_WRITE_VERIFY_EN
    typedef enum logic [1:0] {IDLE, ACCESS, VERIFY, RESP} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
`endif
    state_t state;
    logic in_range;
    assign in_range = req_addr < AWIDTH'(ALENGTH);
    // Addr/WriDat double as the latched request; WE2 doubles as the latched store flag during ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            Addr      <= '0;
            WriDat    <= '0;
            WE2       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid && req_ready) begin
                    req_ready <= 1'b0;
                    if (in_range) begin
                        state  <= ACCESS;
                        Addr   <= req_addr;
                        WriDat <= req_wdata;
                        WE2    <= req_we;
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end
                end
                ACCESS: begin
                    WE2       <= 1'b0;
                    rsp_rdata <= WE2 ? '0 : ReaDat;
                    rsp_err   <= 1'b0;
`ifdef DMEM_WRITE_VERIFY_EN
                    if (WE2) begin
                        state <= VERIFY;
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end
`else
                    state     <= RESP;
                    rsp_valid <= 1'b1;
`endif
                end
`ifdef DMEM_WRITE_VERIFY_EN
                VERIFY: begin
                    rsp_err   <= ReaDat != WriDat;
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                end
`endif
                RESP: if (rsp_ready) begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: scoreboard bench with a word-array memory model for dmem_access_ctrl
module tb_dmem_access_ctrl;
`ifdef DMEM_WRITE_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif
    logic clk = 0, rst = 1;
    logic req_valid = 0, req_ready, req_we = 0, rsp_valid, rsp_ready = 0, rsp_err, WE2;
    logic [31:0] req_addr = 0, req_wdata = 0, rsp_rdata, Addr, WriDat, ReaDat;
    logic [31:0] mem [128];
    logic [31:0] ref_mem [128];
    logic corrupt = 0, hold = 0;
    int cyc = 0, n_chk = 0, n_fail = 0;
    typedef struct {logic [31:0] rdata; logic err; int lat; int acc;} rsp_t;
    typedef struct {logic [31:0] a; logic [31:0] d;} wr_t;
    rsp_t sq[$];
    wr_t wq[$];

    dmem_access_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .Addr(Addr), .WriDat(WriDat), .WE2(WE2), .ReaDat(ReaDat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (WE2) mem[Addr[6:0]] <= WriDat;
    assign ReaDat = (Addr < 32'd128 ? mem[Addr[6:0]] : 32'd0) ^ {31'd0, corrupt};

    initial forever begin
        @(posedge clk);
        #1 rsp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic seen = 0, prev_we2 = 0, held_err;
    logic [31:0] held_rdata;
    rsp_t cur;
    wr_t w;
    always @(negedge clk) begin
        if (WE2) begin
            chk("we2_single_cycle", 32'(prev_we2), 32'd0);
            if (wq.size() == 0) chk("we2_unexpected", 32'd1, 32'd0);
            else begin
                w = wq.pop_front();
                chk("we2_addr", Addr, w.a);
                chk("we2_wdata", WriDat, w.d);
            end
        end
        prev_we2 = WE2;
        if (rsp_valid) begin
            chk("req_ready_busy", 32'(req_ready), 32'd0);
            if (!seen) begin
                seen = 1;
                held_rdata = rsp_rdata;
                held_err = rsp_err;
                if (sq.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
                else begin
                    cur = sq.pop_front();
                    chk("rsp_latency", 32'(cyc - cur.acc + 1), 32'(cur.lat));
                    chk("rsp_rdata", rsp_rdata, cur.rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(cur.err));
                end
            end else begin
                chk("rsp_rdata_stable", rsp_rdata, held_rdata);
                chk("rsp_err_stable", 32'(rsp_err), 32'(held_err));
            end
            if (rsp_ready) seen = 0;
        end else seen = 0;
    end

    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        rsp_t e;
        wr_t x;
        req_valid = 1; req_we = we; req_addr = a; req_wdata = d;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_accept_timeout", 32'd1, 32'd0);
            req_valid = 0;
            return;
        end
        e.acc = cyc + 1;
        if (a >= 32'd128) begin
            e.rdata = 0; e.err = 1; e.lat = 1;
        end else if (we) begin
            ref_mem[a[6:0]] = d;
            e.rdata = 0; e.err = VER && corrupt; e.lat = VER ? 3 : 2;
            x.a = a; x.d = d;
            wq.push_back(x);
        end else begin
            e.rdata = ref_mem[a[6:0]]; e.err = 0; e.lat = 2;
        end
        sq.push_back(e);
        @(posedge clk);
        #1 req_valid = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sq.size() != 0 || rsp_valid) && n < 200);
        if (n >= 200) chk("drain_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem[i] = 0;
            ref_mem[i] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_addr", Addr, 32'd0);
        chk("reset_wridat", WriDat, 32'd0);
        chk("reset_we2", 32'(WE2), 32'd0);
        @(posedge clk);
        #1 rst = 0;
        issue(1, 32'h37, 32'h6000);
        issue(0, 32'h37, 0);
        issue(1, 32'hFFFF_FFFF, 32'h6001);
        issue(0, 32'h80, 0);
        issue(0, 32'h7F, 0);
        wait_idle();
        hold = 1;
        issue(0, 32'h37, 0);
        repeat (6) @(negedge clk);
        chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("hold_req_ready", 32'(req_ready), 32'd0);
        hold = 0;
        wait_idle();
        issue(1, 32'h20, 32'h1234_5678);
        rst = 1;
        void'(sq.pop_back());
        @(posedge clk);
        @(negedge clk);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_we2", 32'(WE2), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 rst = 0;
        issue(1, 32'h10, 32'hA5A5_A5A5);
        issue(0, 32'h10, 0);
        wait_idle();
        corrupt = 1;
        issue(1, 32'h11, 32'h0F0F_0F0F);
        wait_idle();
        corrupt = 0;
        for (int i = 0; i < 150; i++) begin
            int r;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            a = r < 6 ? 32'($urandom_range(0, 127)) : r == 6 ? 32'h7F : r == 7 ? 32'h80 :
                r == 8 ? 32'($urandom) : 32'($urandom_range(0, 15));
            issue(1'($urandom_range(0, 1)), a, 32'($urandom));
        end
        wait_idle();
        chk("scoreboard_empty", 32'(sq.size()), 32'd0);
        chk("write_queue_empty", 32'(wq.size()), 32'd0);
        begin
            int bad = 0;
            for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) bad++;
            chk("memory_contents", 32'(bad), 32'd0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
